// File: rtl/btn_pkg.sv
// Shared types and defaults for the button front end.
package btn_pkg;

  localparam int NBTN_DEF         = 7;
  localparam int STABLE_TICKS_DEF = 3;
  localparam int HOLD_TICKS_DEF   = 16;
  localparam int REPEAT_TICKS_DEF = 4;
  localparam int CODE_W_DEF       = $clog2(NBTN_DEF);

  // Auto-repeat controller states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } fsm_state_t;

  // Width of a button index; a single button still needs one bit
  function automatic int code_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer followed by a tick-driven debounce counter.
module btn_debounce import btn_pkg::*; #(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(STABLE_TICKS) + 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  // Count ticks of disagreement; any agreement restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (sync_q[1] == level) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
        level <= ~level;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_frontend.sv
// Debounced button bank with press / auto-repeat event generation and a
// one-deep valid/ready event register.
module button_frontend import btn_pkg::*; #(
  parameter int NBTN         = NBTN_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [NBTN-1:0]           btn_raw,
  output logic [NBTN-1:0]           btn_level,
  output logic                      any_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [code_w(NBTN)-1:0]   evt_code,
  output logic                      evt_repeat,
  output logic                      evt_drop
);

  localparam int CW    = code_w(NBTN);
  localparam int MAXT  = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W = $clog2(MAXT) + 1;

  fsm_state_t       state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NBTN-1:0]  level_prev_q;
  logic [NBTN-1:0]  rise;
  logic             multi_rise;
  logic [CW-1:0]    press_idx;
  logic             gen_vld, gen_rep, drop_d;
  logic [CW-1:0]    gen_code;

  btn_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_deb [NBTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (btn_raw),
    .level (btn_level)
  );

  assign any_level  = |btn_level;
  assign rise       = btn_level & ~level_prev_q;
  assign multi_rise = |(rise & (rise - NBTN'(1)));

  // Remember last cycle's levels for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev_q <= '0;
    else     level_prev_q <= btn_level;
  end

  // Lowest rising index wins
  always_comb begin
    press_idx = '0;
    for (int i = NBTN - 1; i >= 0; i--)
      if (rise[i]) press_idx = CW'(i);
  end

  // FSM state, active button and tick counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and event generation; a new press preempts everything
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    gen_vld  = 1'b0;
    gen_rep  = 1'b0;
    gen_code = k_q;
    if (|rise) begin
      gen_vld  = 1'b1;
      gen_code = press_idx;
      state_d  = S_PRESSED;
      k_d      = press_idx;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_PRESSED, S_REPEAT: begin
          if (!btn_level[k_q]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == ((state_q == S_PRESSED) ? CNT_W'(HOLD_TICKS - 1)
                                                 : CNT_W'(REPEAT_TICKS - 1))) begin
              gen_vld = 1'b1;
              gen_rep = 1'b1;
              cnt_d   = '0;
              state_d = S_REPEAT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A multi-press or an event meeting a stalled slot costs one drop pulse
  assign drop_d = multi_rise | (gen_vld & evt_valid & ~evt_ready);

  // One-deep event slot: accept frees it, a same-cycle new event refills it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      evt_repeat <= 1'b0;
      evt_drop   <= 1'b0;
    end else begin
      evt_drop <= drop_d;
      if (gen_vld && (!evt_valid || evt_ready)) begin
        evt_valid  <= 1'b1;
        evt_code   <= gen_code;
        evt_repeat <= gen_rep;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_frontend.sv
// Directed bench for button_frontend with hand-derived expectations.
module tb_button_frontend;
  import btn_pkg::*;

  logic       clk = 0;
  logic       rst = 1;
  logic       tick = 0;
  logic [6:0] btn_raw = '0;
  logic [6:0] btn_level;
  logic       any_level;
  logic       evt_valid;
  logic       evt_ready = 1;
  logic [2:0] evt_code;
  logic       evt_repeat;
  logic       evt_drop;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int code; bit rep; int tk; } ev_t;
  ev_t evq[$];
  int  drops = 0;
  int  tick_cnt = 0;
  int  ph = 0;

  button_frontend dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw),
    .btn_level(btn_level), .any_level(any_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_repeat(evt_repeat), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  // Prescaler model: one tick cycle in every four clocks
  initial forever begin
    @(posedge clk); #1;
    tick = (ph == 3);
    ph = (ph + 1) % 4;
  end

  // Record accepted events and drop pulses mid-cycle
  always @(negedge clk) begin
    if (tick) tick_cnt++;
    if (!rst && evt_valid && evt_ready) evq.push_back('{int'(evt_code), evt_repeat, tick_cnt});
    if (evt_drop) drops++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic clear_log();
    evq.delete();
    drops = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({btn_level, any_level, evt_valid, evt_code, evt_repeat, evt_drop} !== 13'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {btn_level, any_level, evt_valid, evt_code, evt_repeat, evt_drop});
    end
    n_cmp++; if (dut.state_q !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_IDLE); end
    rst = 0;
    wait_ticks(2);
  endtask

  task automatic test_press();
    clear_log();
    wait_ticks(1);
    btn_raw[3] = 1;
    wait_ticks(2);
    n_cmp++; if (btn_level !== 7'h00) begin n_bad++; $display("FAIL press_level_early: got %h want 00", btn_level); end
    wait_ticks(1);
    n_cmp++; if (btn_level !== 7'h08) begin n_bad++; $display("FAIL press_level: got %h want 08", btn_level); end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL press_valid_early: got %b want 0", evt_valid); end
    @(posedge clk); #1;
    n_cmp++; if ({evt_valid, evt_code, evt_repeat, any_level} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL press_event: got v=%b c=%0d r=%b any=%b want v=1 c=3 r=0 any=1", evt_valid, evt_code, evt_repeat, any_level);
    end
    @(posedge clk); #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL press_accepted: valid got %b want 0", evt_valid); end
    btn_raw[3] = 0;
    wait_ticks(4);
    n_cmp++; if (btn_level !== 7'h00) begin n_bad++; $display("FAIL press_release: got %h want 00", btn_level); end
    n_cmp++; if (evq.size() !== 1) begin n_bad++; $display("FAIL press_count: got %0d want 1", evq.size()); end
  endtask

  task automatic test_glitch();
    clear_log();
    wait_ticks(1);
    btn_raw[2] = 1;
    wait_ticks(2);
    btn_raw[2] = 0;
    wait_ticks(4);
    n_cmp++; if (btn_level !== 7'h00) begin n_bad++; $display("FAIL glitch_level: got %h want 00", btn_level); end
    n_cmp++; if (evq.size() !== 0) begin n_bad++; $display("FAIL glitch_events: got %0d want 0", evq.size()); end
  endtask

  task automatic test_repeat();
    int exp_off [4] = '{16, 20, 24, 28};
    clear_log();
    wait_ticks(1);
    btn_raw[0] = 1;
    wait_ticks(30);
    btn_raw[0] = 0;
    wait_ticks(10);
    n_cmp++; if (evq.size() !== 5) begin n_bad++; $display("FAIL repeat_count: got %0d want 5", evq.size()); end
    if (evq.size() >= 1) begin
      n_cmp++; if (evq[0].code !== 0 || evq[0].rep !== 1'b0) begin
        n_bad++; $display("FAIL repeat_press: got c=%0d r=%b want c=0 r=0", evq[0].code, evq[0].rep);
      end
    end
    for (int i = 1; i < 5 && i < evq.size(); i++) begin
      n_cmp++; if (evq[i].code !== 0 || evq[i].rep !== 1'b1 || (evq[i].tk - evq[0].tk) !== exp_off[i-1]) begin
        n_bad++; $display("FAIL repeat_%0d: got c=%0d r=%b off=%0d want c=0 r=1 off=%0d",
                          i, evq[i].code, evq[i].rep, evq[i].tk - evq[0].tk, exp_off[i-1]);
      end
    end
    n_cmp++; if (dut.state_q !== S_IDLE) begin n_bad++; $display("FAIL repeat_idle: got %0d want %0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_multi();
    clear_log();
    wait_ticks(1);
    btn_raw = 7'b0100010;
    wait_ticks(3);
    @(posedge clk); #1;
    n_cmp++; if ({evt_valid, evt_code, evt_drop} !== {1'b1, 3'd1, 1'b1}) begin
      n_bad++; $display("FAIL multi_event: got v=%b c=%0d d=%b want v=1 c=1 d=1", evt_valid, evt_code, evt_drop);
    end
    @(posedge clk); #1;
    n_cmp++; if (evt_drop !== 1'b0) begin n_bad++; $display("FAIL multi_drop_pulse: got %b want 0", evt_drop); end
    btn_raw = '0;
    wait_ticks(5);
    n_cmp++; if (evq.size() !== 1 || drops !== 1) begin
      n_bad++; $display("FAIL multi_totals: got events=%0d drops=%0d want 1 1", evq.size(), drops);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    evt_ready = 0;
    wait_ticks(1);
    btn_raw[4] = 1;
    wait_ticks(3);
    @(posedge clk); #1;
    n_cmp++; if ({evt_valid, evt_code} !== {1'b1, 3'd4}) begin
      n_bad++; $display("FAIL bp_first: got v=%b c=%0d want v=1 c=4", evt_valid, evt_code);
    end
    wait_ticks(1);
    btn_raw[6] = 1;
    wait_ticks(3);
    @(posedge clk); #1;
    n_cmp++; if ({evt_valid, evt_code, evt_repeat, evt_drop} !== {1'b1, 3'd4, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL bp_blocked: got v=%b c=%0d r=%b d=%b want v=1 c=4 r=0 d=1", evt_valid, evt_code, evt_repeat, evt_drop);
    end
    repeat (2) @(posedge clk);
    #1;
    evt_ready = 1;
    @(posedge clk); #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: valid got %b want 0", evt_valid); end
    btn_raw = '0;
    wait_ticks(5);
    n_cmp++; if (evq.size() !== 1 || drops !== 1) begin
      n_bad++; $display("FAIL bp_totals: got events=%0d drops=%0d want 1 1", evq.size(), drops);
    end
    if (evq.size() >= 1) begin
      n_cmp++; if (evq[0].code !== 4 || evq[0].rep !== 1'b0) begin
        n_bad++; $display("FAIL bp_code: got c=%0d r=%b want c=4 r=0", evq[0].code, evq[0].rep);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    clear_log();
    wait_ticks(1);
    btn_raw[2] = 1;
    wait_ticks(21);
    n_cmp++; if (dut.state_q !== S_REPEAT || evq.size() !== 2) begin
      n_bad++; $display("FAIL rr_pre: got state=%0d events=%0d want state=%0d events=2", dut.state_q, evq.size(), S_REPEAT);
    end
    rst = 1;
    #1;
    n_cmp++; if ({btn_level, any_level, evt_valid, evt_code, evt_repeat, evt_drop} !== 13'd0) begin
      n_bad++; $display("FAIL rr_async: got %b want 0", {btn_level, any_level, evt_valid, evt_code, evt_repeat, evt_drop});
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    clear_log();
    wait_ticks(5);
    n_cmp++; if (evq.size() !== 1) begin n_bad++; $display("FAIL rr_count: got %0d want 1", evq.size()); end
    if (evq.size() >= 1) begin
      n_cmp++; if (evq[0].code !== 2 || evq[0].rep !== 1'b0) begin
        n_bad++; $display("FAIL rr_event: got c=%0d r=%b want c=2 r=0", evq[0].code, evq[0].rep);
      end
    end
    btn_raw = '0;
    wait_ticks(5);
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_repeat();
    test_multi();
    test_back_to_back();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_frontend.md
BUTTON_FRONTEND -- requirements
Module: button_frontend

Interface
REQ-001 SHALL have parameter NBTN, default 7: number of button inputs.
REQ-002 SHALL have parameter STABLE_TICKS, default 3: ticks of unchanged input required to change a debounced level.
REQ-003 SHALL have parameter HOLD_TICKS, default 16: ticks a button is held before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_TICKS, default 4: ticks between subsequent auto-repeats.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port tick, input, 1 bit: single-cycle sample strobe from the shared prescaler.
REQ-008 SHALL have port btn_raw, input, NBTN bits: asynchronous button pins, active-high.
REQ-009 SHALL have port btn_level, output, NBTN bits: debounced button levels.
REQ-010 SHALL have port any_level, output, 1 bit: OR of btn_level.
REQ-011 SHALL have port evt_valid, output, 1 bit: an event is pending.
REQ-012 SHALL have port evt_ready, input, 1 bit: the consumer accepts the event.
REQ-013 SHALL have port evt_code, output, clog2(NBTN) bits: index of the button that caused the event.
REQ-014 SHALL have port evt_repeat, output, 1 bit: 0 = initial press, 1 = auto-repeat.
REQ-015 SHALL have port evt_drop, output, 1 bit: one-cycle pulse when an event is lost.

Function
REQ-016 SHALL pass each btn_raw bit through a two-flop synchronizer before any other use.
REQ-017 SHALL debounce each bit with a per-button counter: on a tick where sync != level, increment; when the counter reaches STABLE_TICKS-1 and sync still differs, toggle level and clear the counter; when sync == level, clear the counter.
REQ-018 SHALL change btn_level only on tick cycles; a glitch shorter than STABLE_TICKS ticks SHALL NOT change it.
REQ-019 SHALL produce a press event on the cycle following a btn_level 0->1 transition.
REQ-020 SHALL report the lowest index when several levels rise in the same cycle, discard the others, and pulse evt_drop once.
REQ-021 SHALL implement the FSM IDLE, PRESSED, REPEAT holding the active index k and a tick counter.
REQ-022 SHALL transition IDLE->PRESSED on a press of k, clearing the counter.
REQ-023 In PRESSED, SHALL increment the counter per tick; at HOLD_TICKS SHALL emit a repeat event for k, clear the counter, and enter REPEAT.
REQ-024 In REPEAT, SHALL emit a repeat event for k every REPEAT_TICKS ticks.
REQ-025 In PRESSED or REPEAT, a fall of btn_level[k] SHALL return the FSM to IDLE with no event.
REQ-026 In PRESSED or REPEAT, a press of a different button SHALL emit its press event, retarget k, clear the counter, and enter PRESSED.
REQ-027 SHALL hold evt_valid, evt_code and evt_repeat stable until the cycle where evt_valid and evt_ready are both high.
REQ-028 SHALL drop a new event arriving while evt_valid=1 and evt_ready=0, keep the pending one, and pulse evt_drop.
REQ-029 SHALL load a new event arriving in the same cycle as an accept, with no drop and no bubble.
REQ-030 Press latency SHALL be 2 clk (sync) + STABLE_TICKS ticks (debounce) + 1 clk (level to evt_valid).

Reset
REQ-031 On rst=1 SHALL asynchronously clear the synchronizers, counters, btn_level, any_level, evt_valid, evt_code, evt_repeat and evt_drop, and set the FSM to IDLE.
REQ-032 Buttons held through reset release SHALL be debounced afresh and SHALL produce a press event, not a repeat.

Structure
REQ-033 Package btn_pkg SHALL hold the FSM state enum, parameter defaults and the code-width constant.
REQ-034 Per-bit synchronizer and debounce SHALL be sub-module btn_debounce, instantiated NBTN times.

Verification
REQ-035 Bench: tick every 4 clk, evt_ready=1; raise btn_raw[3] -> btn_level[3] rises after 3 ticks; one event code=3, repeat=0.
REQ-036 Bench: pulse btn_raw[2] for 2 ticks -> no btn_level change, no event.
REQ-037 Bench: hold btn_raw[0] for 30 ticks -> press, then repeats at 16, 20, 24 and 28 ticks after press; release -> FSM IDLE, no further events.
REQ-038 Bench: raise btn_raw[1] and btn_raw[5] simultaneously -> one event code=1, evt_drop pulses once.
REQ-039 Bench: evt_ready=0 with a press of 4, then a press of 6 -> code=4 stays pending, evt_drop pulses; after evt_ready=1, code=4 is accepted once.
REQ-040 Bench: assert rst mid-REPEAT on button 2 -> all outputs 0 immediately; on release with button still held, the next event is code=2, repeat=0.
